// File: rtl/decimal_operand_entry.sv
// -----------------------------------------------------------------------------
// decimal_operand_entry
//
// Operand entry path for the switch/key calculator. The user sets one decimal
// digit on four switches and confirms it with a push-button. This block
// conditions the three raw buttons, accumulates the digits into a binary
// operand plus a BCD image for the seven-segment decoders, and hands the
// finished operand to the calculator core over a VALID/ACK handshake.
//
// Optional build macro: DECIMAL_ENTRY_SIGN_EN
//   When defined, the block gains a NEG output. ENTER with digit 4'hA on an
//   empty entry toggles NEG, and while NEG is set the top BCD nibble shows the
//   dash code 4'hA. When undefined, 4'hA is rejected like any other non-digit.
//
// Ports:
//   CLOCK_50      in   1            system clock
//   RST_N         in   1            asynchronous reset, active low
//   SW_DIGIT      in   4            digit to enter (0..9 accepted)
//   KEY_ENTER_N   in   1            raw button, active low: append digit
//   KEY_BACK_N    in   1            raw button, active low: delete last digit
//   KEY_COMMIT_N  in   1            raw button, active low: operand complete
//   ACK           in   1            consumer has taken VALUE
//   VALUE         out  VALUE_W      binary value of the entered digits
//   BCD           out  4*MAX_DIGITS entered digits, nibble 0 = newest,
//                                   unused nibbles read 4'hF (blank)
//   COUNT         out  3            number of digits entered
//   VALID         out  1            operand committed, waiting for ACK
//   ERR           out  1            one-cycle pulse on a rejected action
//   NEG           out  1            sign flag (DECIMAL_ENTRY_SIGN_EN only)
// -----------------------------------------------------------------------------
module decimal_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MAX_DIGITS      = 3,
    parameter int VALUE_W         = 10
) (
    input  logic                    CLOCK_50,
    input  logic                    RST_N,
    input  logic [3:0]              SW_DIGIT,
    input  logic                    KEY_ENTER_N,
    input  logic                    KEY_BACK_N,
    input  logic                    KEY_COMMIT_N,
    input  logic                    ACK,
    output logic [VALUE_W-1:0]      VALUE,
    output logic [4*MAX_DIGITS-1:0] BCD,
    output logic [2:0]              COUNT,
    output logic                    VALID,
    output logic                    ERR
`ifdef DECIMAL_ENTRY_SIGN_EN
    ,
    output logic                    NEG
`endif
);

    localparam int BCD_W = 4 * MAX_DIGITS;

    // The debounce counter runs 0..DEBOUNCE_CYCLES-1 while the synchronized
    // level disagrees with the accepted level.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0]       MAX_CNT  = 3'(MAX_DIGITS);
    localparam logic [BCD_W-1:0] BLANK    = '1;
    // 4'hF in the most significant nibble, zeros elsewhere; OR-ed in when the
    // digit image shifts right so the vacated position reads blank.
    localparam logic [BCD_W-1:0] TOP_F    = BCD_W'(4'hF) << (BCD_W - 4);

    localparam int KEY_ENTER  = 0;
    localparam int KEY_BACK   = 1;
    localparam int KEY_COMMIT = 2;

    // -------------------------------------------------------------------------
    // Key conditioning: 2-FF synchronizer, debounce counter, press detector.
    // -------------------------------------------------------------------------
    logic [2:0] key_raw;
    logic [2:0] key_ev;

    assign key_raw = {KEY_COMMIT_N, KEY_BACK_N, KEY_ENTER_N};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
            logic             s1_reg;
            logic             s2_reg;
            logic             db_reg;
            logic             ev_reg;
            logic [CNT_W-1:0] cnt_reg;

            // Released (high) is the idle level, so a reset never looks like
            // a press.
            always_ff @(posedge CLOCK_50 or negedge RST_N) begin
                if (!RST_N) begin
                    s1_reg  <= 1'b1;
                    s2_reg  <= 1'b1;
                    db_reg  <= 1'b1;
                    ev_reg  <= 1'b0;
                    cnt_reg <= '0;
                end else begin
                    s1_reg <= key_raw[gi];
                    s2_reg <= s1_reg;
                    ev_reg <= 1'b0;
                    if (s2_reg != db_reg) begin
                        if (cnt_reg == CNT_LAST) begin
                            // Level accepted; only a falling edge (press)
                            // generates an event, releases are silent.
                            db_reg  <= s2_reg;
                            cnt_reg <= '0;
                            ev_reg  <= ~s2_reg;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        // Any agreement restarts the stability window.
                        cnt_reg <= '0;
                    end
                end
            end

            assign key_ev[gi] = ev_reg;
        end
    endgenerate

    // Switches are slow, but they are still asynchronous to CLOCK_50; they
    // settle through two flops long before a debounced press can arrive.
    logic [3:0] sw_s1_reg;
    logic [3:0] sw_s2_reg;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            sw_s1_reg <= 4'h0;
            sw_s2_reg <= 4'h0;
        end else begin
            sw_s1_reg <= SW_DIGIT;
            sw_s2_reg <= sw_s1_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Entry state machine.
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             state_reg;
    logic [VALUE_W-1:0] value_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [2:0]         count_reg;
    logic               valid_reg;
    logic               err_reg;

    logic enter_ev;
    logic back_ev;
    logic commit_ev;
    logic digit_bad;
    logic entry_full;
    logic entry_empty;

    assign enter_ev    = key_ev[KEY_ENTER];
    assign back_ev     = key_ev[KEY_BACK];
    assign commit_ev   = key_ev[KEY_COMMIT];
    assign digit_bad   = (sw_s2_reg > 4'd9);
    assign entry_full  = (count_reg == MAX_CNT);
    assign entry_empty = (count_reg == 3'd0);

`ifdef DECIMAL_ENTRY_SIGN_EN
    logic neg_reg;
    logic sign_toggle;

    // 4'hA on an empty entry is the minus key; anywhere else it is a bad digit.
    assign sign_toggle = (sw_s2_reg == 4'hA) && entry_empty;
`endif

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= ST_ENTRY;
            value_reg <= '0;
            bcd_reg   <= BLANK;
            count_reg <= 3'd0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
`ifdef DECIMAL_ENTRY_SIGN_EN
            neg_reg   <= 1'b0;
`endif
        end else begin
            // ERR is a pulse: it only survives the cycle that raised it.
            err_reg <= 1'b0;

            case (state_reg)
                ST_ENTRY: begin
                    // COMMIT beats BACK beats ENTER; losers are dropped.
                    if (commit_ev) begin
                        if (!entry_empty) begin
                            valid_reg <= 1'b1;
                            state_reg <= ST_HOLD;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end else if (back_ev) begin
                        // Backspace on an empty entry is harmless, no ERR.
                        if (!entry_empty) begin
                            value_reg <= value_reg / VALUE_W'(10);
                            bcd_reg   <= (bcd_reg >> 4) | TOP_F;
                            count_reg <= count_reg - 3'd1;
                        end
                    end else if (enter_ev) begin
`ifdef DECIMAL_ENTRY_SIGN_EN
                        if (sign_toggle) begin
                            neg_reg <= ~neg_reg;
                        end else
`endif
                        if (digit_bad || entry_full) begin
                            err_reg <= 1'b1;
                        end else begin
                            // Width is sized so VALUE*10+digit cannot
                            // overflow for MAX_DIGITS digits.
                            value_reg <= VALUE_W'(value_reg * VALUE_W'(10))
                                         + VALUE_W'(sw_s2_reg);
                            bcd_reg   <= (bcd_reg << 4) | BCD_W'(sw_s2_reg);
                            count_reg <= count_reg + 3'd1;
                        end
                    end
                end

                ST_HOLD: begin
                    // Operand is frozen and keys are ignored until the core
                    // takes it; ACK clears everything for the next operand.
                    if (ACK) begin
                        state_reg <= ST_ENTRY;
                        value_reg <= '0;
                        bcd_reg   <= BLANK;
                        count_reg <= 3'd0;
                        valid_reg <= 1'b0;
`ifdef DECIMAL_ENTRY_SIGN_EN
                        neg_reg   <= 1'b0;
`endif
                    end
                end

                default: begin
                    state_reg <= ST_ENTRY;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign VALUE = value_reg;
    assign COUNT = count_reg;
    assign VALID = valid_reg;
    assign ERR   = err_reg;

`ifdef DECIMAL_ENTRY_SIGN_EN
    assign NEG = neg_reg;
    // The dash overlays the top display position only; the stored digits are
    // untouched so BACK still shifts the real digit image.
    assign BCD = neg_reg ? {4'hA, bcd_reg[BCD_W-5:0]} : bcd_reg;
`else
    assign BCD = bcd_reg;
`endif

endmodule

// File: tb/tb_decimal_operand_entry.sv
// -----------------------------------------------------------------------------
// tb_decimal_operand_entry
//
// Directed steps followed by a randomized key sequence. Expected outputs come
// from a digit-list model: the entered digits are kept in a queue, VALUE is
// the decimal fold of the queue, BCD is the queue laid out newest-first.
// -----------------------------------------------------------------------------
module tb_decimal_operand_entry;

    localparam int DB = 4;
    localparam int MD = 3;
    localparam int VW = 10;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    sw    = 4'h0;
    logic [2:0]    key_n = 3'b111;   // {commit, back, enter}
    logic          ack   = 1'b0;
    logic [VW-1:0] value;
    logic [11:0]   bcd;
    logic [2:0]    count;
    logic          valid;
    logic          err;

    int vectors     = 0;
    int miscompares = 0;
    int err_seen    = 0;
    int exp_err     = 0;

    int digits[$];
    bit hold = 1'b0;

    decimal_operand_entry #(
        .DEBOUNCE_CYCLES (DB),
        .MAX_DIGITS      (MD),
        .VALUE_W         (VW)
    ) dut (
        .CLOCK_50     (clk),
        .RST_N        (rst_n),
        .SW_DIGIT     (sw),
        .KEY_ENTER_N  (key_n[0]),
        .KEY_BACK_N   (key_n[1]),
        .KEY_COMMIT_N (key_n[2]),
        .ACK          (ack),
        .VALUE        (value),
        .BCD          (bcd),
        .COUNT        (count),
        .VALID        (valid),
        .ERR          (err)
    );

    always #5 clk = ~clk;

    // Every cycle ERR is high counts once, so a stretched pulse is an error.
    always @(negedge clk) if (err === 1'b1) err_seen++;

    initial begin
        #1ms;
        $error("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int m_value();
        int v = 0;
        foreach (digits[i]) v = v * 10 + digits[i];
        return v;
    endfunction

    function automatic logic [11:0] m_bcd();
        logic [11:0] b = 12'hFFF;
        for (int i = 0; i < digits.size(); i++)
            b[4*i +: 4] = 4'(digits[digits.size() - 1 - i]);
        return b;
    endfunction

    task automatic m_keys(input logic [2:0] mask, input int d);
        if (hold) return;
        if (mask[2]) begin
            if (digits.size() > 0) hold = 1'b1;
            else exp_err++;
        end else if (mask[1]) begin
            if (digits.size() > 0) void'(digits.pop_back());
        end else if (mask[0]) begin
            if (d > 9 || digits.size() == MD) exp_err++;
            else digits.push_back(d);
        end
    endtask

    task automatic m_ack();
        if (hold) begin
            hold = 1'b0;
            digits.delete();
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".value"}, 32'(value), 32'(m_value()));
        chk({tag, ".bcd"},   32'(bcd),   32'(m_bcd()));
        chk({tag, ".count"}, 32'(count), 32'(digits.size()));
        chk({tag, ".valid"}, 32'(valid), 32'(hold));
        chk({tag, ".err"},   32'(err_seen), 32'(exp_err));
        $display("step %-12s value=%0d bcd=%03h count=%0d valid=%0b errs=%0d",
                 tag, value, bcd, count, valid, err_seen);
    endtask

    // ---------------- stimulus helpers ----------------
    // Hold the selected keys low long enough to pass the debouncer, then
    // release and let the release settle before anything is checked.
    task automatic hit(input logic [2:0] mask, input int d, input string tag);
        @(negedge clk);
        sw    = 4'(d);
        key_n = ~mask;
        repeat (10) @(negedge clk);
        key_n = 3'b111;
        repeat (10) @(negedge clk);
        m_keys(mask, d);
        check_all(tag);
    endtask

    task automatic pulse_ack(input string tag);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        m_ack();
        check_all(tag);
    endtask

    // ---------------- sequence ----------------
    initial begin
        // Reset state, observed while reset is still asserted.
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1,2,3 then COMMIT; VALID holds without ACK; ACK clears.
        hit(3'b001, 1, "e1");
        hit(3'b001, 2, "e2");
        hit(3'b001, 3, "e3");
        hit(3'b100, 0, "commit123");
        chk("value123", 32'(value), 32'd123);
        chk("bcd123",   32'(bcd),   32'h123);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("valid_hold", 32'(valid), 32'd1);
        end
        pulse_ack("ack");
        chk("bcd_blank", 32'(bcd), 32'hFFF);

        // Overflow and bad digit are rejected.
        hit(3'b001, 1, "e1");
        hit(3'b001, 2, "e2");
        hit(3'b001, 3, "e3");
        hit(3'b001, 4, "full");
        hit(3'b001, 12, "bad12");
        hit(3'b010, 0, "bk");
        hit(3'b010, 0, "bk");
        hit(3'b010, 0, "bk");

        // Backspace, backspace on empty, commit on empty.
        hit(3'b001, 4, "e4");
        hit(3'b001, 7, "e7");
        hit(3'b010, 0, "bk47");
        chk("bcd_ff4", 32'(bcd), 32'hFF4);
        hit(3'b010, 0, "bk");
        hit(3'b010, 0, "bk_empty");
        hit(3'b100, 0, "commit_empty");

        // A 3-cycle bounce is filtered; a 10-cycle press counts once.
        @(negedge clk);
        sw       = 4'd8;
        key_n[0] = 1'b0;
        repeat (3) @(negedge clk);
        key_n[0] = 1'b1;
        repeat (15) @(negedge clk);
        check_all("bounce");
        hit(3'b001, 8, "e8");

        // COMMIT and ENTER in the same cycle: commit wins, digit dropped.
        hit(3'b001, 2, "e2");
        hit(3'b101, 9, "commit_enter");
        hit(3'b001, 5, "hold_enter");
        hit(3'b010, 0, "hold_back");
        hit(3'b100, 0, "hold_commit");
        pulse_ack("ack2");

        // Reset between edges clears outputs without a clock edge.
        hit(3'b001, 5, "e5");
        hit(3'b001, 6, "e6");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        digits.delete();
        hold = 1'b0;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Random key sequence against the model.
        for (int n = 0; n < 40; n++) begin
            int pick;
            int d;
            pick = int'($urandom_range(0, 9));
            d    = int'($urandom_range(0, 11));
            if (pick < 5)       hit(3'b001, d, "r_enter");
            else if (pick < 7)  hit(3'b010, d, "r_back");
            else if (pick == 7) hit(3'b100, d, "r_commit");
            else if (pick == 8) hit(3'b111, d, "r_all");
            else                pulse_ack("r_ack");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decimal_operand_entry.md
Name: decimal_operand_entry

Overview:
- Operand input path for the switch/key calculator; the reverse of the result display path.
- The user keys in a decimal number one digit at a time: a 4-bit digit on switches, confirmed by a push-button.
- The block debounces the buttons and accumulates the digits into a binary operand.
- It exports the entered digits as BCD for the seven-segment decoders and hands the finished operand to the calculator core with a VALID/ACK handshake.

Parameters:
- DEBOUNCE_CYCLES, 250000, number of consecutive stable cycles before a raw key level is accepted (5 ms at 50 MHz).
- MAX_DIGITS, 3, maximum number of decimal digits per operand.
- VALUE_W, 10, width of the binary operand. Must satisfy 10^MAX_DIGITS-1 < 2^VALUE_W.

Ports:
- CLOCK_50  in  1  system clock.
- RST_N  in  1  reset.
- SW_DIGIT  in  4  digit to enter; valid range 0..9.
- KEY_ENTER_N  in  1  raw push-button, active-low: append digit.
- KEY_BACK_N  in  1  raw push-button, active-low: delete last digit.
- KEY_COMMIT_N  in  1  raw push-button, active-low: operand complete.
- ACK  in  1  consumer has taken VALUE.
- VALUE  out  VALUE_W  binary value of the digits entered.
- BCD  out  4*MAX_DIGITS  entered digits; nibble 0 is the last digit entered; unused nibbles = 4'hF (blank).
- COUNT  out  3  number of digits entered, 0..MAX_DIGITS.
- VALID  out  1  operand committed, waiting for ACK.
- ERR  out  1  one-cycle pulse on a rejected action.

Behaviour:
- Clocking and reset: one clock, CLOCK_50. Reset RST_N is asynchronous and active-low.
- Reset values: VALUE=0, BCD=all 4'hF, COUNT=0, VALID=0, ERR=0, state=ENTRY, debouncers=released. Reset asserted mid-entry or in HOLD discards everything immediately.
- Key conditioning:
  - Each KEY_*_N passes through a 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - A debounced 1->0 transition produces a one-cycle press event. Release produces nothing; holding a key produces no repeats.
- Event priority within a single cycle: COMMIT > BACK > ENTER. Lower-priority events in the same cycle are dropped, not deferred.
- State ENTRY:
  - ENTER, SW_DIGIT<=9, COUNT<MAX_DIGITS: VALUE<=VALUE*10+SW_DIGIT; BCD shifts left one nibble with SW_DIGIT in nibble 0; COUNT+1. Leading zeros are kept as digits ("0","5" gives COUNT=2, VALUE=5, BCD=..F05).
  - ENTER, SW_DIGIT>9: ERR pulse; no other change.
  - ENTER, COUNT==MAX_DIGITS: ERR pulse; no other change.
  - BACK, COUNT>0: VALUE<=VALUE/10; BCD shifts right with 4'hF in the top nibble; COUNT-1.
  - BACK, COUNT==0: no-op, no ERR.
  - COMMIT, COUNT>0: VALID<=1; go to HOLD.
  - COMMIT, COUNT==0: ERR pulse; stay in ENTRY.
  - ACK is ignored in ENTRY.
- State HOLD:
  - VALID=1; VALUE, BCD and COUNT are frozen.
  - All key events are ignored, with no ERR.
  - ACK=1: next cycle VALID=0, VALUE=0, COUNT=0, BCD=all F, state=ENTRY.
- Latency: outputs update on the clock edge after the press event. The press event occurs 2+DEBOUNCE_CYCLES cycles after a clean raw edge. VALID asserts on the edge after the COMMIT event.
- Arithmetic: all values are unsigned; no saturation is needed, guaranteed by the VALUE_W constraint. ERR is registered and is high for exactly one cycle per rejected event.

Optional Feature:
- Macro: DECIMAL_ENTRY_SIGN_EN.
- When defined:
  - Adds output NEG (1 bit), reset value 0.
  - ENTER with SW_DIGIT==4'hA and COUNT==0 toggles NEG instead of appending a digit.
  - While NEG=1, the top BCD nibble reads 4'hA (dash code); MAX_DIGITS is unchanged. NEG is frozen in HOLD and cleared with the other outputs on ACK.
  - SW_DIGIT==4'hA with COUNT>0 raises ERR.
- When not defined: no NEG port; 4'hA is rejected with ERR like any other value >9.

Test Plan:
- (Bench uses DEBOUNCE_CYCLES=4 throughout.) Enter 1,2,3, then COMMIT -> VALUE=123, BCD=0x123, COUNT=3, VALID=1. VALID stays high 10 cycles with ACK=0; ACK pulse -> VALUE=0, BCD=0xFFF, VALID=0 next cycle.
- Enter 1,2,3, then ENTER with digit 4 -> ERR one cycle, VALUE stays 123. ENTER with digit 12 -> ERR, no change.
- Enter 4,7, then BACK -> VALUE=4, BCD=0xFF4, COUNT=1. BACK twice more -> COUNT=0, no ERR. COMMIT -> ERR, VALID=0.
- Raw KEY_ENTER_N low for 3 cycles, then high (bounce) -> no press event, COUNT unchanged. Low for 10 cycles -> exactly one digit appended.
- COMMIT and ENTER events in the same cycle with COUNT=2 -> HOLD entered, digit not appended. Keys pressed in HOLD -> no change, no ERR.
- Enter 5,6, then deassert RST_N between clock edges -> all outputs at reset values immediately, with no clock edge required.
